// File: rtl/example_passive_collector.sv
// -----------------------------------------------------------------------------
// example_passive_collector
//
// Passive receive end of the pipelined/folded A-channel. Watches
// valid_00H / opcode_01H / beat_0nH / data_0nH, reassembles each transaction
// (one opcode + BEATS data beats) into a single word, and queues the words in
// a small first-word-fall-through FIFO presented on a valid/ready port. The
// channel is never backpressured. When the FIFO is full and no pop happens
// in the same cycle, the completed transaction is dropped and counted.
//
// Optional build macro: EXAMPLE_PASSIVE_COLLECTOR_PROTO_CHECK_EN
//   defined     -> beat-order and start-spacing protocol checks drive the
//                  sticky err_beat / err_spacing flags and report with $error.
//   not defined -> beat_0nH is ignored and both error flags are tied to 0.
//
// Ports
//   clk, rst     clock (posedge) and synchronous active-high reset
//   valid_00H    transaction start (cycle N)
//   opcode_01H   opcode, valid in cycle N+1
//   beat_0nH     beat index, cycles N+2..N+1+BEATS
//   data_0nH     beat data,  cycles N+2..N+1+BEATS
//   txn_valid    FIFO head valid
//   txn_ready    consumer accepts the head
//   txn_opcode   head opcode
//   txn_data     head data, beat k at [k*DATA_W +: DATA_W]
//   fifo_count   occupied FIFO entries (0..FIFO_DEPTH)
//   overflow     sticky: at least one transaction dropped
//   drop_count   dropped transactions, saturating
//   err_beat     sticky beat-order error (check macro only)
//   err_spacing  sticky start-spacing error (check macro only)
//
// BEATS must be >= 2. FIFO_DEPTH must be a power of 2 and >= 2.
// -----------------------------------------------------------------------------
module example_passive_collector #(
    parameter  int OP_W       = 4,
    parameter  int DATA_W     = 8,
    parameter  int BEATS      = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_W      = 16,
    localparam int BEAT_W     = $clog2(BEATS),
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int FCNT_W     = PTR_W + 1,
    localparam int WORD_W     = BEATS * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_00H,
    input  logic [OP_W-1:0]   opcode_01H,
    input  logic [BEAT_W-1:0] beat_0nH,
    input  logic [DATA_W-1:0] data_0nH,
    output logic              txn_valid,
    input  logic              txn_ready,
    output logic [OP_W-1:0]   txn_opcode,
    output logic [WORD_W-1:0] txn_data,
    output logic [FCNT_W-1:0] fifo_count,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    output logic              err_beat,
    output logic              err_spacing
);

    typedef enum logic {IDLE, COLLECT} state_t;

    // start-spacing guard and stage-1 pipeline
    logic [BEAT_W-1:0] space_q, space_d;
    logic              pend1_q, pend1_d;
    logic [OP_W-1:0]   op_pend_q, op_pend_d;
    logic              start_ok;

    // assembly FSM
    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [OP_W-1:0]   op_act_q, op_act_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] asm_cur;
    logic              push;

    // output FIFO
    logic [OP_W-1:0]   mem_op_q   [FIFO_DEPTH];
    logic [OP_W-1:0]   mem_op_d   [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              pop, full, do_push, drop;

    // ---------------------------------------------------------------- stage 1
    // space_q counts the cycles still blocked after an accepted start; a
    // start is only accepted once it has run down to zero (BEATS-cycle spacing).
    always_comb begin
        start_ok  = valid_00H && (space_q == '0);
        space_d   = space_q;
        if (start_ok)
            space_d = BEAT_W'(BEATS - 1);
        else if (space_q != '0)
            space_d = space_q - 1'b1;
        pend1_d   = start_ok;
        op_pend_d = pend1_q ? opcode_01H : op_pend_q;
    end

    // ---------------------------------------------------------------- assembly
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        op_act_d   = op_act_q;
        asm_d      = asm_q;
        push       = 1'b0;

        // current beat merged into the assembly, so the last beat can be pushed
        // in the same cycle it arrives
        asm_cur = asm_q;
        asm_cur[int'(beat_cnt_q) * DATA_W +: DATA_W] = data_0nH;

        case (state_q)
            IDLE: begin
                if (pend1_q) begin
                    state_d    = COLLECT;
                    beat_cnt_d = '0;
                end
            end
            COLLECT: begin
                asm_d = asm_cur;
                // op_pend is free to be reused by a back-to-back transaction
                // once it has been handed over on the first beat
                if (beat_cnt_q == '0)
                    op_act_d = op_pend_q;
                if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                    push       = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = pend1_q ? COLLECT : IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        pop     = txn_valid && txn_ready;
        full    = (count_q == FCNT_W'(FIFO_DEPTH));
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = push && (!full || pop);
        drop    = push && full && !pop;

        mem_op_d   = mem_op_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (do_push) begin
            mem_op_d[wr_ptr_q]   = op_act_q;
            mem_data_d[wr_ptr_q] = asm_cur;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop;
        drop_d     = drop_q;
        if (drop && (drop_q != '1))
            drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            space_q    <= '0;
            pend1_q    <= 1'b0;
            op_pend_q  <= '0;
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            op_act_q   <= '0;
            asm_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_op_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            space_q    <= space_d;
            pend1_q    <= pend1_d;
            op_pend_q  <= op_pend_d;
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            op_act_q   <= op_act_d;
            asm_q      <= asm_d;
            mem_op_q   <= mem_op_d;
            mem_data_q <= mem_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign txn_valid  = (count_q != '0);
    assign txn_opcode = mem_op_q[rd_ptr_q];
    assign txn_data   = mem_data_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    // ---------------------------------------------------------------- checks
`ifdef EXAMPLE_PASSIVE_COLLECTOR_PROTO_CHECK_EN
    logic err_beat_q, err_beat_d;
    logic err_spacing_q, err_spacing_d;
    logic beat_ev, spacing_ev;

    always_comb begin
        beat_ev       = (state_q == COLLECT) && (beat_0nH != beat_cnt_q);
        spacing_ev    = valid_00H && !start_ok;
        err_beat_d    = err_beat_q | beat_ev;
        err_spacing_d = err_spacing_q | spacing_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_beat_q    <= 1'b0;
            err_spacing_q <= 1'b0;
        end else begin
            err_beat_q    <= err_beat_d;
            err_spacing_q <= err_spacing_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (beat_ev)
                $error("%m: beat index %0d seen where %0d expected", beat_0nH, beat_cnt_q);
            if (spacing_ev)
                $error("%m: start ignored, too close to previous start");
        end
    end

    assign err_beat    = err_beat_q;
    assign err_spacing = err_spacing_q;
`else
    // beat_0nH is only consumed by the protocol check
    logic unused_beat;
    assign unused_beat = ^beat_0nH;
    assign err_beat    = 1'b0;
    assign err_spacing = 1'b0;
`endif

endmodule

// File: tb/tb_example_passive_collector.sv
module tb_example_passive_collector;

`ifdef EXAMPLE_PASSIVE_COLLECTOR_PROTO_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_00H;
    logic [3:0]  opcode_01H;
    logic [1:0]  beat_0nH;
    logic [7:0]  data_0nH;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_opcode;
    logic [31:0] txn_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        err_beat;
    logic        err_spacing;

    example_passive_collector dut (
        .clk        (clk),
        .rst        (rst),
        .valid_00H  (valid_00H),
        .opcode_01H (opcode_01H),
        .beat_0nH   (beat_0nH),
        .data_0nH   (data_0nH),
        .txn_valid  (txn_valid),
        .txn_ready  (txn_ready),
        .txn_opcode (txn_opcode),
        .txn_data   (txn_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .err_beat   (err_beat),
        .err_spacing(err_spacing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // per-cycle channel schedule, indexed by cycle within the current scenario
    logic       v_s  [0:63];
    logic [3:0] op_s [0:63];
    logic [1:0] bt_s [0:63];
    logic [7:0] dt_s [0:63];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_sched();
        for (int i = 0; i < 64; i++) begin
            v_s[i]  = 1'b0;
            op_s[i] = 4'h0;
            bt_s[i] = 2'd0;
            dt_s[i] = 8'h00;
        end
        cyc = 0;
    endtask

    task automatic sched(input int s, input logic [3:0] op, input logic [31:0] d);
        v_s[s]    = 1'b1;
        op_s[s+1] = op;
        for (int k = 0; k < 4; k++) begin
            bt_s[s+2+k] = 2'(k);
            dt_s[s+2+k] = d[k*8 +: 8];
        end
    endtask

    // drive cycle 'cyc' from the schedule, then move to 1 time unit after the
    // edge that ends it
    task automatic step();
        if (cyc < 64) begin
            valid_00H  = v_s[cyc];
            opcode_01H = op_s[cyc];
            beat_0nH   = bt_s[cyc];
            data_0nH   = dt_s[cyc];
        end else begin
            valid_00H  = 1'b0;
            opcode_01H = 4'h0;
            beat_0nH   = 2'd0;
            data_0nH   = 8'h00;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        clr_sched();
        txn_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clr_sched();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst        = 1'b1;
        txn_ready  = 1'b0;
        valid_00H  = 1'b0;
        opcode_01H = 4'h0;
        beat_0nH   = 2'd0;
        data_0nH   = 8'h00;
        #1;
        do_reset();

        // reset state
        chk("rst_valid", 64'(txn_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_opcode", 64'(txn_opcode), 64'd0);
        chk("rst_data", 64'(txn_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_err_beat", 64'(err_beat), 64'd0);
        chk("rst_err_spacing", 64'(err_spacing), 64'd0);

        // 1. single transaction, head appears in cycle 6
        sched(0, 4'ha, 32'h11100f0e);
        steps(5);
        chk("t1_valid_c5", 64'(txn_valid), 64'd0);
        step();
        chk("t1_valid_c6", 64'(txn_valid), 64'd1);
        chk("t1_opcode", 64'(txn_opcode), 64'ha);
        chk("t1_data", 64'(txn_data), 64'h11100f0e);
        chk("t1_count", 64'(fifo_count), 64'd1);
        txn_ready = 1'b1;
        step();
        txn_ready = 1'b0;
        chk("t1_count_after_pop", 64'(fifo_count), 64'd0);
        chk("t1_valid_after_pop", 64'(txn_valid), 64'd0);

        // 2. back-to-back starts at 0 and 4, always ready
        do_reset();
        sched(0, 4'ha, 32'h03020100);
        sched(4, 4'hb, 32'h13121110);
        txn_ready = 1'b1;
        steps(6);
        chk("t2_valid_c6", 64'(txn_valid), 64'd1);
        chk("t2_op_a", 64'(txn_opcode), 64'ha);
        chk("t2_data_a", 64'(txn_data), 64'h03020100);
        step();
        chk("t2_valid_c7", 64'(txn_valid), 64'd0);
        steps(3);
        chk("t2_valid_c10", 64'(txn_valid), 64'd1);
        chk("t2_op_b", 64'(txn_opcode), 64'hb);
        chk("t2_data_b", 64'(txn_data), 64'h13121110);
        step();
        chk("t2_count_c11", 64'(fifo_count), 64'd0);
        chk("t2_overflow", 64'(overflow), 64'd0);
        chk("t2_drop", 64'(drop_count), 64'd0);
        txn_ready = 1'b0;

        // 3. overflow: five transactions, never ready; pushes end cycles 5,9,13,17,21
        do_reset();
        for (int i = 1; i <= 5; i++)
            sched((i - 1) * 4, 4'(i), 32'h01010101 * 32'(i));
        steps(18);
        chk("t3_count_c18", 64'(fifo_count), 64'd4);
        chk("t3_overflow_c18", 64'(overflow), 64'd0);
        chk("t3_head_c18", 64'(txn_opcode), 64'h1);
        steps(4);
        chk("t3_count_c22", 64'(fifo_count), 64'd4);
        chk("t3_overflow_c22", 64'(overflow), 64'd1);
        chk("t3_drop_c22", 64'(drop_count), 64'd1);
        chk("t3_head_stable", 64'(txn_opcode), 64'h1);
        chk("t3_data_stable", 64'(txn_data), 64'h01010101);
        txn_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain_op", 64'(txn_opcode), 64'(i));
            chk("t3_drain_data", 64'(txn_data), 64'(32'h01010101 * 32'(i)));
            step();
        end
        chk("t3_empty", 64'(fifo_count), 64'd0);
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);
        txn_ready = 1'b0;

        // 4. full FIFO with push and pop in the same cycle (cycle 21)
        do_reset();
        for (int i = 1; i <= 5; i++)
            sched((i - 1) * 4, 4'(i), 32'h01010101 * 32'(i));
        steps(21);
        chk("t4_count_c21", 64'(fifo_count), 64'd4);
        txn_ready = 1'b1;
        step();
        txn_ready = 1'b0;
        chk("t4_count_c22", 64'(fifo_count), 64'd4);
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_drop", 64'(drop_count), 64'd0);
        txn_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("t4_drain_op", 64'(txn_opcode), 64'(i));
            step();
        end
        chk("t4_empty", 64'(fifo_count), 64'd0);
        txn_ready = 1'b0;

        // 5. reset in cycle 3 of a transaction discards it
        do_reset();
        sched(0, 4'h6, 32'h66666666);
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid_in_rst", 64'(txn_valid), 64'd0);
        chk("t5_count_in_rst", 64'(fifo_count), 64'd0);
        steps(8);
        chk("t5_no_push_valid", 64'(txn_valid), 64'd0);
        chk("t5_no_push_count", 64'(fifo_count), 64'd0);
        clr_sched();
        sched(0, 4'h7, 32'hdeadbeef);
        steps(6);
        chk("t5_clean_valid", 64'(txn_valid), 64'd1);
        chk("t5_clean_op", 64'(txn_opcode), 64'h7);
        chk("t5_clean_data", 64'(txn_data), 64'hdeadbeef);

        // 6a. beat index order 0,2,1,3: data still placed by arrival order
        do_reset();
        sched(0, 4'hc, 32'h44332211);
        bt_s[3] = 2'd2;
        bt_s[4] = 2'd1;
        steps(6);
        chk("t6_beat_valid", 64'(txn_valid), 64'd1);
        chk("t6_beat_op", 64'(txn_opcode), 64'hc);
        chk("t6_beat_data", 64'(txn_data), 64'h44332211);
        chk("t6_err_beat", 64'(err_beat), 64'(PCHK));
        chk("t6_err_spacing_clean", 64'(err_spacing), 64'd0);

        // 6b. starts at 0 and 2: second one ignored
        do_reset();
        sched(0, 4'h8, 32'h87654321);
        v_s[2]  = 1'b1;
        op_s[3] = 4'h9;
        steps(12);
        chk("t6_sp_count", 64'(fifo_count), 64'd1);
        chk("t6_sp_op", 64'(txn_opcode), 64'h8);
        chk("t6_sp_data", 64'(txn_data), 64'h87654321);
        chk("t6_err_spacing", 64'(err_spacing), 64'(PCHK));
        chk("t6_err_beat_clean", 64'(err_beat), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
